crosswalk_request_scheduler: RTL and testbench

//  Front end for two_way_intersection pedestrian buttons: synchronizes and debounces both

---
 rtl/crosswalk_request_scheduler_if.sv | 26 ++
 rtl/crosswalk_request_scheduler.sv | 149 ++++++++++++++
 tb/tb_crosswalk_request_scheduler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/crosswalk_request_scheduler_if.sv
// Extension handshake between the crosswalk scheduler and the intersection phase FSM.
// Handshake: ext_req_k rises when approach k is pending and eligible and stays high until the
// intersection pulses ext_ack for one cycle or eligibility is lost; at most one ext_req_k is high.
interface crosswalk_request_scheduler_if;
  logic [2:0] phase;
  logic       ext_window;
  logic       ext_ack;
  logic       ext_req_0;
  logic       ext_req_1;

  modport master (
    input  phase,
    input  ext_window,
    input  ext_ack,
    output ext_req_0,
    output ext_req_1
  );

  modport slave (
    output phase,
    output ext_window,
    output ext_ack,
    input  ext_req_0,
    input  ext_req_1
  );
endinterface

// File: rtl/crosswalk_request_scheduler.sv
// Synchronizes and debounces two active-low crosswalk buttons, latches requests and grants
// at most one green-extension per eligible phase through a req/ack handshake.
module crosswalk_request_scheduler #(
  parameter int DEBOUNCE = 4,
  parameter int HOLDOFF  = 10,
  parameter int CNT_W    = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                crosswalk_0,
  input  logic                                crosswalk_1,
  crosswalk_request_scheduler_if.master       bus,
  output logic                                pend_0,
  output logic                                pend_1,
  output logic                                busy,
  output logic [1:0]                          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ0 = 2'd1,
    S_REQ1 = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLDOFF);

  logic [1:0]       w_raw;
  logic [1:0]       r_sync0;
  logic [1:0]       r_sync1;
  logic [1:0]       r_acc;
  logic [1:0]       r_press;
  logic [CNT_W-1:0] r_dbcnt [2];

  assign w_raw = {crosswalk_1, crosswalk_0};

  // r_acc holds the accepted pressed state (1 = pressed); r_press pulses on release->press only.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_sync0 <= 2'b11;
      r_sync1 <= 2'b11;
      r_acc   <= 2'b00;
      r_press <= 2'b00;
      for (int k = 0; k < 2; k++) r_dbcnt[k] <= '0;
    end else begin
      r_sync0 <= w_raw;
      r_sync1 <= r_sync0;
      for (int k = 0; k < 2; k++) begin
        r_press[k] <= 1'b0;
        if ((~r_sync1[k]) != r_acc[k]) begin
          if (r_dbcnt[k] >= DB_LAST) begin
            r_acc[k]   <= ~r_acc[k];
            r_dbcnt[k] <= '0;
            r_press[k] <= ~r_acc[k];
          end else begin
            r_dbcnt[k] <= r_dbcnt[k] + CNT_W'(1);
          end
        end else begin
          r_dbcnt[k] <= '0;
        end
      end
    end
  end

  state_t           r_state;
  logic             r_req_0;
  logic             r_req_1;
  logic             r_pend_0;
  logic             r_pend_1;
  logic             r_served;
  logic [CNT_W-1:0] r_hold;
  logic             w_elig_0;
  logic             w_elig_1;
  logic             w_take_0;
  logic             w_take_1;
  logic [2:0]       w_served_phase;

  assign w_elig_0       = (bus.phase == 3'd3) && bus.ext_window;
  assign w_elig_1       = (bus.phase == 3'd0) && bus.ext_window;
  // Approach 1 is served in phase 0, approach 0 in phase 3.
  assign w_served_phase = r_served ? 3'd0 : 3'd3;
  assign w_take_0       = r_press[0] && !((r_state == S_HOLD) && !r_served);
  assign w_take_1       = r_press[1] && !((r_state == S_HOLD) &&  r_served);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state  <= S_IDLE;
      r_req_0  <= 1'b0;
      r_req_1  <= 1'b0;
      r_pend_0 <= 1'b0;
      r_pend_1 <= 1'b0;
      r_served <= 1'b0;
      r_hold   <= '0;
    end else begin
      if (w_take_0) r_pend_0 <= 1'b1;
      if (w_take_1) r_pend_1 <= 1'b1;
      // Clears below come later in the block so an ack beats a same-cycle press.
      case (r_state)
        S_IDLE: begin
          if (r_pend_1 && w_elig_1) begin
            r_state <= S_REQ1;
            r_req_1 <= 1'b1;
          end else if (r_pend_0 && w_elig_0) begin
            r_state <= S_REQ0;
            r_req_0 <= 1'b1;
          end
        end
        S_REQ0: begin
          if (bus.ext_ack) begin
            r_pend_0 <= 1'b0;
            r_hold   <= HOLD_INIT;
            r_served <= 1'b0;
            r_req_0  <= 1'b0;
            r_state  <= S_HOLD;
          end else if (!w_elig_0) begin
            r_req_0  <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_REQ1: begin
          if (bus.ext_ack) begin
            r_pend_1 <= 1'b0;
            r_hold   <= HOLD_INIT;
            r_served <= 1'b1;
            r_req_1  <= 1'b0;
            r_state  <= S_HOLD;
          end else if (!w_elig_1) begin
            r_req_1  <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (r_hold != '0) r_hold <= r_hold - CNT_W'(1);
          if ((r_hold == '0) && (bus.phase != w_served_phase)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ext_req_0 = r_req_0;
  assign bus.ext_req_1 = r_req_1;
  assign pend_0        = r_pend_0;
  assign pend_1        = r_pend_1;
  assign busy          = (r_state != S_IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_crosswalk_request_scheduler.sv
// Directed bench for crosswalk_request_scheduler: debounce latency, grant/ack, drop, holdoff
// and mid-handshake reset, with expected output vectors queued and popped at each check.
module tb_crosswalk_request_scheduler;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ0 = 2'd1;
  localparam logic [1:0] ST_REQ1 = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic       clk;
  logic       reset_n;
  logic       crosswalk_0;
  logic       crosswalk_1;
  logic       pend_0;
  logic       pend_1;
  logic       busy;
  logic [1:0] dbg_state;
  logic [6:0] w_obs;

  logic [6:0] exp_q[$];
  int         n_cmp;
  int         n_err;

  crosswalk_request_scheduler_if u_if ();

  crosswalk_request_scheduler #(
    .DEBOUNCE (4),
    .HOLDOFF  (10),
    .CNT_W    (8)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .crosswalk_0 (crosswalk_0),
    .crosswalk_1 (crosswalk_1),
    .bus         (u_if.master),
    .pend_0      (pend_0),
    .pend_1      (pend_1),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // Observation vector: {state, ext_req_1, ext_req_0, pend_1, pend_0, busy}
  assign w_obs = {dbg_state, u_if.ext_req_1, u_if.ext_req_0, pend_1, pend_0, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [6:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag);
    logic [6:0] e;
    logic [6:0] got;
    got = w_obs;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %b required a queued expectation", tag, got);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (got === e) else begin
        n_err++;
        $error("FAIL %s: got %b required %b", tag, got, e);
      end
    end
  endtask

  task automatic expect_obs(input string tag, input logic [6:0] e);
    push_exp(e);
    check(tag);
  endtask

  initial begin
    logic [2:0] p;
    n_cmp = 0;
    n_err = 0;
    crosswalk_0     = 1'b1;
    crosswalk_1     = 1'b1;
    reset_n         = 1'b1;
    u_if.phase      = 3'd2;
    u_if.ext_window = 1'b0;
    u_if.ext_ack    = 1'b0;

    // T1: reset with both buttons held down, then debounce latency out of reset
    crosswalk_0 = 1'b0;
    crosswalk_1 = 1'b0;
    tick(3);
    expect_obs("t1_reset", {ST_IDLE, 5'b00000});
    reset_n = 1'b0;
    tick(6);
    expect_obs("t1_pend_early", {ST_IDLE, 5'b00000});
    tick(1);
    expect_obs("t1_pend_latency", {ST_IDLE, 5'b00110});
    crosswalk_0 = 1'b1;
    crosswalk_1 = 1'b1;
    tick(10);
    reset_n = 1'b1;
    tick(1);
    expect_obs("t1_reset_clears", {ST_IDLE, 5'b00000});
    reset_n = 1'b0;
    tick(2);

    // T2: short glitch rejected, then a long press
    crosswalk_1 = 1'b0;
    tick(3);
    crosswalk_1 = 1'b1;
    tick(10);
    expect_obs("t2_short_glitch", {ST_IDLE, 5'b00000});
    crosswalk_1 = 1'b0;
    tick(6);
    expect_obs("t2_pend_early", {ST_IDLE, 5'b00000});
    tick(1);
    expect_obs("t2_pend_latch", {ST_IDLE, 5'b00100});

    // T3: grant and ack while the button stays held
    u_if.phase      = 3'd0;
    u_if.ext_window = 1'b1;
    tick(1);
    expect_obs("t3_req", {ST_REQ1, 5'b10101});
    tick(3);
    expect_obs("t3_req_held", {ST_REQ1, 5'b10101});
    u_if.ext_ack = 1'b1;
    tick(1);
    u_if.ext_ack = 1'b0;
    expect_obs("t3_ack", {ST_HOLD, 5'b00001});
    tick(15);
    expect_obs("t3_hold_same_phase", {ST_HOLD, 5'b00001});
    u_if.phase      = 3'd1;
    u_if.ext_window = 1'b0;
    tick(1);
    expect_obs("t3_hold_exit", {ST_IDLE, 5'b00000});
    tick(22);
    expect_obs("t2_no_repeat", {ST_IDLE, 5'b00000});
    crosswalk_1 = 1'b1;
    tick(10);
    expect_obs("t2_release", {ST_IDLE, 5'b00000});

    // T4: request dropped on loss of eligibility, re-requested later
    crosswalk_0 = 1'b0;
    tick(7);
    crosswalk_0 = 1'b1;
    expect_obs("t4_pend0", {ST_IDLE, 5'b00010});
    u_if.phase      = 3'd3;
    u_if.ext_window = 1'b1;
    tick(1);
    expect_obs("t4_req0", {ST_REQ0, 5'b01011});
    u_if.ext_window = 1'b0;
    tick(1);
    expect_obs("t4_drop", {ST_IDLE, 5'b00010});
    u_if.ext_ack = 1'b1;
    tick(1);
    u_if.ext_ack = 1'b0;
    expect_obs("t4_ack_idle_ignored", {ST_IDLE, 5'b00010});
    for (int i = 0; i < 6; i++) begin
      p = 3'($urandom_range(0, 6));
      if (p >= 3'd3) p = p + 3'd1;
      u_if.phase      = p;
      u_if.ext_window = 1'($urandom_range(0, 1));
      tick(1);
      expect_obs("t4_inelig_phase", {ST_IDLE, 5'b00010});
    end
    u_if.phase      = 3'd3;
    u_if.ext_window = 1'b1;
    tick(1);
    expect_obs("t4_rereq", {ST_REQ0, 5'b01011});
    u_if.ext_ack    = 1'b1;
    u_if.ext_window = 1'b0;
    tick(1);
    u_if.ext_ack = 1'b0;
    expect_obs("t4_ack_beats_drop", {ST_HOLD, 5'b00001});
    u_if.phase = 3'd4;
    tick(10);
    expect_obs("t4_holdoff_last", {ST_HOLD, 5'b00001});
    tick(1);
    expect_obs("t4_holdoff_exit", {ST_IDLE, 5'b00000});

    // T5: press of the served approach during holdoff is discarded, other approach latched
    crosswalk_1 = 1'b0;
    tick(7);
    crosswalk_1 = 1'b1;
    expect_obs("t5_pend1", {ST_IDLE, 5'b00100});
    tick(8);
    u_if.phase      = 3'd0;
    u_if.ext_window = 1'b1;
    tick(1);
    expect_obs("t5_req1", {ST_REQ1, 5'b10101});
    u_if.ext_ack = 1'b1;
    tick(1);
    u_if.ext_ack = 1'b0;
    expect_obs("t5_ack1", {ST_HOLD, 5'b00001});
    crosswalk_1 = 1'b0;
    tick(8);
    crosswalk_1 = 1'b1;
    expect_obs("t5_press_in_hold_dropped", {ST_HOLD, 5'b00001});
    tick(8);
    crosswalk_0 = 1'b0;
    tick(7);
    crosswalk_0 = 1'b1;
    expect_obs("t5_other_latched", {ST_HOLD, 5'b00011});
    u_if.phase      = 3'd3;
    u_if.ext_window = 1'b1;
    tick(1);
    expect_obs("t5_hold_exit", {ST_IDLE, 5'b00010});
    tick(1);
    expect_obs("t5_grant0", {ST_REQ0, 5'b01011});

    // T6: reset in the middle of a handshake with another request pending
    crosswalk_1 = 1'b0;
    tick(7);
    expect_obs("t6_setup", {ST_REQ0, 5'b01111});
    reset_n = 1'b1;
    tick(1);
    expect_obs("t6_reset_midop", {ST_IDLE, 5'b00000});
    crosswalk_1 = 1'b1;
    reset_n     = 1'b0;
    tick(10);
    expect_obs("t6_after_reset", {ST_IDLE, 5'b00000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
